// File: rtl/argmax_stream_if.sv
// Beat/result bundle for argmax_stream. With ARGMAX_SECOND_EN defined it also
// carries the runner-up value and its position.
interface argmax_stream_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2,
  parameter int IDX_W  = 8
);
  logic                    EN_COMP;
  logic                    trig;
  logic                    last;
  logic                    min_mode;
  logic [LANES*DATA_W-1:0] din;
  logic                    busy;
  logic                    done;
  logic [IDX_W-1:0]        index;
  logic [DATA_W-1:0]       largest;
  logic                    ovf;
`ifdef ARGMAX_SECOND_EN
  logic [DATA_W-1:0]       second;
  logic [IDX_W-1:0]        index2;
`endif

  modport master (
    output EN_COMP, trig, last, min_mode, din,
    input  busy, done, index, largest, ovf
`ifdef ARGMAX_SECOND_EN
    , input second, index2
`endif
  );

  modport slave (
    input  EN_COMP, trig, last, min_mode, din,
    output busy, done, index, largest, ovf
`ifdef ARGMAX_SECOND_EN
    , output second, index2
`endif
  );
endinterface

// File: rtl/argmax_stream.sv
// Streaming arg-max/arg-min: lane reduction per beat, then frame accumulation.
// Define ARGMAX_SECOND_EN to also track the runner-up (second/index2).
module argmax_stream #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2,
  parameter int IDX_W  = 8
) (
  input logic             CLKEXT,
  input logic             RST_COMP,
  argmax_stream_if.slave  bus
);

  // Positions are kept wide enough that base + lane + 1 never wraps.
  localparam int PW = IDX_W + 1 + $clog2(LANES + 1);
  localparam logic [PW-1:0] SAT = PW'((1 << IDX_W) - 1);
  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {S_FIRST, S_MID} frame_state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] val;
    logic [IDX_W-1:0]         idx;   // 0 marks an empty slot
  } cand_t;

  localparam cand_t EMPTY = '{val: MIN_VAL, idx: '0};

  function automatic logic better(logic signed [DATA_W-1:0] a, logic signed [DATA_W-1:0] b,
                                  logic mode);
    return mode ? (a < b) : (a > b);
  endfunction

  function automatic logic [IDX_W-1:0] clip(logic [PW-1:0] p);
    return (p > SAT) ? IDX_W'(SAT) : IDX_W'(p);
  endfunction

`ifdef ARGMAX_SECOND_EN
  typedef struct packed {
    cand_t top;
    cand_t run;
  } pair_t;

  // Candidates must arrive in position order; strict compares keep earlier ties ahead.
  function automatic pair_t insert2(pair_t p, cand_t c, logic mode);
    pair_t r;
    r = p;
    if (c.idx != '0) begin
      if (better(c.val, p.top.val, mode)) begin
        r.top = c;
        r.run = p.top;
      end else if (p.run.idx == '0 || better(c.val, p.run.val, mode)) begin
        r.run = c;
      end
    end
    return r;
  endfunction
`endif

  frame_state_e state_q, state_d;
  logic [PW-1:0] base_q, base_d;
  logic          mode_q, mode_d;

  logic          s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_first_q, s1_first_d;
  logic          s1_mode_q, s1_mode_d, s1_ovf_q, s1_ovf_d;
  cand_t         s1_best_q, s1_best_d;

  logic          s2_last_q, s2_last_d, busy_q, busy_d;
  logic          acc_mode_q, acc_mode_d, acc_ovf_q, acc_ovf_d;
  cand_t         acc_best_q, acc_best_d;

  logic                     done_q, done_d, ovf_q, ovf_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic signed [DATA_W-1:0] largest_q, largest_d;

`ifdef ARGMAX_SECOND_EN
  cand_t                    s1_run_q, s1_run_d, acc_run_q, acc_run_d;
  logic [IDX_W-1:0]         index2_q, index2_d;
  logic signed [DATA_W-1:0] second_q, second_d;
  pair_t                    beat_p, merge_p;
`endif

  logic          accept, first, beat_mode, beat_ovf;
  logic [PW-1:0] beat_base;
  cand_t         lane_c;

  // Front end: frame tracking and in-beat reduction.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    accept    = bus.trig && bus.EN_COMP;
    first     = (state_q == S_FIRST);
    beat_base = first ? '0 : base_q;
    beat_mode = first ? bus.min_mode : mode_q;
    beat_ovf  = (beat_base + PW'(LANES)) > SAT;
    state_d   = state_q;
    base_d    = base_q;
    mode_d    = mode_q;
    lane_c    = EMPTY;
    if (accept) begin
      state_d = bus.last ? S_FIRST : S_MID;
      mode_d  = beat_mode;
      base_d  = (beat_base > SAT) ? beat_base : beat_base + PW'(LANES);
    end

    s1_best_d.val = bus.din[DATA_W-1:0];
    s1_best_d.idx = clip(beat_base + PW'(1));
`ifdef ARGMAX_SECOND_EN
    beat_p = '{top: s1_best_d, run: EMPTY};
    for (int k = 1; k < LANES; k++) begin
      lane_c.val = bus.din[k*DATA_W +: DATA_W];
      lane_c.idx = clip(beat_base + PW'(k + 1));
      beat_p     = insert2(beat_p, lane_c, beat_mode);
    end
    s1_best_d = beat_p.top;
    s1_run_d  = beat_p.run;
`else
    for (int k = 1; k < LANES; k++) begin
      lane_c.val = bus.din[k*DATA_W +: DATA_W];
      lane_c.idx = clip(beat_base + PW'(k + 1));
      if (better(lane_c.val, s1_best_d.val, beat_mode)) s1_best_d = lane_c;
    end
`endif
    s1_valid_d = accept;
    s1_last_d  = bus.last;
    s1_first_d = first;
    s1_mode_d  = beat_mode;
    s1_ovf_d   = beat_ovf;
  end

  // Frame accumulation and result registers.
  always_comb begin
    acc_best_d = acc_best_q;
    acc_mode_d = acc_mode_q;
    acc_ovf_d  = acc_ovf_q;
`ifdef ARGMAX_SECOND_EN
    acc_run_d  = acc_run_q;
    merge_p    = insert2('{top: acc_best_q, run: acc_run_q}, s1_best_q, acc_mode_q);
    merge_p    = insert2(merge_p, s1_run_q, acc_mode_q);
`endif
    if (s1_valid_q) begin
      if (s1_first_q) begin
        acc_best_d = s1_best_q;
        acc_mode_d = s1_mode_q;
        acc_ovf_d  = s1_ovf_q;
`ifdef ARGMAX_SECOND_EN
        acc_run_d  = s1_run_q;
`endif
      end else begin
`ifdef ARGMAX_SECOND_EN
        acc_best_d = merge_p.top;
        acc_run_d  = merge_p.run;
`else
        if (better(s1_best_q.val, acc_best_q.val, acc_mode_q)) acc_best_d = s1_best_q;
`endif
        acc_ovf_d  = acc_ovf_q | s1_ovf_q;
      end
    end
    s2_last_d = s1_valid_q && s1_last_q;

    busy_d = busy_q;
    if (s2_last_q) busy_d = 1'b0;
    if (s1_valid_q && s1_first_q) busy_d = 1'b1;

    done_d    = s2_last_q;
    index_d   = index_q;
    largest_d = largest_q;
    ovf_d     = ovf_q;
`ifdef ARGMAX_SECOND_EN
    index2_d  = index2_q;
    second_d  = second_q;
`endif
    if (s2_last_q) begin
      index_d   = acc_best_q.idx;
      largest_d = acc_best_q.val;
      ovf_d     = acc_ovf_q;
`ifdef ARGMAX_SECOND_EN
      index2_d  = acc_run_q.idx;
      second_d  = acc_run_q.val;
`endif
    end
  end

  // NOTE: every register, data included, is reset so outputs are defined mid-frame.
  always_ff @(posedge CLKEXT or posedge RST_COMP) begin
    if (RST_COMP) begin
      state_q    <= S_FIRST;
      base_q     <= '0;
      mode_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_first_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s1_best_q  <= EMPTY;
      s2_last_q  <= 1'b0;
      busy_q     <= 1'b0;
      acc_mode_q <= 1'b0;
      acc_ovf_q  <= 1'b0;
      acc_best_q <= EMPTY;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      index_q    <= '0;
      largest_q  <= MIN_VAL;
`ifdef ARGMAX_SECOND_EN
      s1_run_q   <= EMPTY;
      acc_run_q  <= EMPTY;
      index2_q   <= '0;
      second_q   <= MIN_VAL;
`endif
    end else begin
      // NOTE: non-blocking so every stage samples the previous cycle's values.
      state_q    <= state_d;
      base_q     <= base_d;
      mode_q     <= mode_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_first_q <= s1_first_d;
      s1_mode_q  <= s1_mode_d;
      s1_ovf_q   <= s1_ovf_d;
      s1_best_q  <= s1_best_d;
      s2_last_q  <= s2_last_d;
      busy_q     <= busy_d;
      acc_mode_q <= acc_mode_d;
      acc_ovf_q  <= acc_ovf_d;
      acc_best_q <= acc_best_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      index_q    <= index_d;
      largest_q  <= largest_d;
`ifdef ARGMAX_SECOND_EN
      s1_run_q   <= s1_run_d;
      acc_run_q  <= acc_run_d;
      index2_q   <= index2_d;
      second_q   <= second_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.index   = index_q;
  assign bus.largest = largest_q;
  assign bus.ovf     = ovf_q;
`ifdef ARGMAX_SECOND_EN
  assign bus.second  = second_q;
  assign bus.index2  = index2_q;
`endif

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: a LANES=2/IDX_W=8 instance plus an IDX_W=3
// instance for position saturation.
module tb_argmax_stream;

  logic CLKEXT = 1'b0;
  logic RST_COMP;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLKEXT = ~CLKEXT;

  argmax_stream_if #(.DATA_W(16), .LANES(2), .IDX_W(8)) bus ();
  argmax_stream_if #(.DATA_W(16), .LANES(2), .IDX_W(3)) bus_s ();

  argmax_stream #(.DATA_W(16), .LANES(2), .IDX_W(8)) u_dut (
    .CLKEXT   (CLKEXT),
    .RST_COMP (RST_COMP),
    .bus      (bus)
  );

  argmax_stream #(.DATA_W(16), .LANES(2), .IDX_W(3)) u_dut_s (
    .CLKEXT   (CLKEXT),
    .RST_COMP (RST_COMP),
    .bus      (bus_s)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic en, input logic tr, input logic la, input logic mm,
                      input logic [15:0] l0, input logic [15:0] l1);
    @(negedge CLKEXT);
    bus.EN_COMP  = en;
    bus.trig     = tr;
    bus.last     = la;
    bus.min_mode = mm;
    bus.din      = {l1, l0};
  endtask

  task automatic idle();
    beat(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic beat_s(input logic la, input logic [15:0] l0, input logic [15:0] l1);
    @(negedge CLKEXT);
    bus_s.EN_COMP  = 1'b1;
    bus_s.trig     = 1'b1;
    bus_s.last     = la;
    bus_s.min_mode = 1'b0;
    bus_s.din      = {l1, l0};
  endtask

  task automatic idle_s();
    @(negedge CLKEXT);
    bus_s.trig = 1'b0;
    bus_s.last = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [15:0] idx, input logic [15:0] val);
    check({tag, "_done"},    16'(bus.done), 16'd1);
    check({tag, "_index"},   16'(bus.index), idx);
    check({tag, "_largest"}, bus.largest, val);
  endtask

  initial begin
    RST_COMP = 1'b1;
    bus.EN_COMP = 1'b0; bus.trig = 1'b0; bus.last = 1'b0; bus.min_mode = 1'b0; bus.din = '0;
    bus_s.EN_COMP = 1'b0; bus_s.trig = 1'b0; bus_s.last = 1'b0; bus_s.min_mode = 1'b0;
    bus_s.din = '0;
    repeat (2) @(negedge CLKEXT);
    RST_COMP = 1'b0;
    check("rst_done",    16'(bus.done), 16'd0);
    check("rst_busy",    16'(bus.busy), 16'd0);
    check("rst_index",   16'(bus.index), 16'd0);
    check("rst_largest", bus.largest, 16'h8000);
    check("rst_ovf",     16'(bus.ovf), 16'd0);

    // Single-beat frame, max mode: lane0=5, lane1=3.
    beat(1'b1, 1'b1, 1'b1, 1'b0, 16'd5, 16'd3);
    idle();
    check("t1_busy_t0", 16'(bus.busy), 16'd0);
    check("t1_done_t0", 16'(bus.done), 16'd0);
    idle();
    check("t1_busy_t1", 16'(bus.busy), 16'd1);
    check("t1_done_t1", 16'(bus.done), 16'd0);
    idle();
    check_result("t1", 16'd1, 16'd5);
    check("t1_busy_t2", 16'(bus.busy), 16'd0);
    check("t1_ovf",     16'(bus.ovf), 16'd0);
`ifdef ARGMAX_SECOND_EN
    check("t1_second", bus.second, 16'd3);
    check("t1_index2", 16'(bus.index2), 16'd2);
`endif
    idle();
    check("t1_done_pulse", 16'(bus.done), 16'd0);
    check("t1_index_hold", 16'(bus.index), 16'd1);

    // Ties: first 9 (position 3) must win.
    beat(1'b1, 1'b1, 1'b0, 1'b0, 16'd7, 16'd7);
    beat(1'b1, 1'b1, 1'b0, 1'b0, 16'd9, 16'd9);
    beat(1'b1, 1'b1, 1'b1, 1'b0, 16'd9, 16'd2);
    idle();
    idle();
    check("t2_busy", 16'(bus.busy), 16'd1);
    check("t2_done_early", 16'(bus.done), 16'd0);
    idle();
    check_result("t2", 16'd3, 16'd9);
`ifdef ARGMAX_SECOND_EN
    check("t2_second", bus.second, 16'd9);
    check("t2_index2", 16'(bus.index2), 16'd4);
`endif

    // Min mode, with min_mode dropped mid-frame (must be ignored).
    beat(1'b1, 1'b1, 1'b0, 1'b1, 16'(-4), 16'd10);
    beat(1'b1, 1'b1, 1'b1, 1'b0, 16'(-4), 16'(-20));
    idle();
    idle();
    idle();
    check_result("t3", 16'd4, 16'(-20));
`ifdef ARGMAX_SECOND_EN
    check("t3_second", bus.second, 16'(-4));
    check("t3_index2", 16'(bus.index2), 16'd1);
`endif

    // Back-to-back single-beat frames.
    beat(1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 16'd2);
    beat(1'b1, 1'b1, 1'b1, 1'b0, 16'(-1), 16'(-2));
    idle();
    check("t4_done_early", 16'(bus.done), 16'd0);
    idle();
    check_result("t4a", 16'd2, 16'd2);
    check("t4a_busy", 16'(bus.busy), 16'd1);
    idle();
    check_result("t4b", 16'd1, 16'(-1));
    check("t4b_busy", 16'(bus.busy), 16'd0);
    idle();
    check("t4_done_end", 16'(bus.done), 16'd0);

    // IDX_W=3: position 8 saturates to 7 and flags ovf.
    beat_s(1'b0, 16'd1, 16'd2);
    beat_s(1'b0, 16'd3, 16'd4);
    beat_s(1'b0, 16'd5, 16'd0);
    beat_s(1'b1, 16'd6, 16'd9);
    idle_s();
    idle_s();
    idle_s();
    check("t5_done",    16'(bus_s.done), 16'd1);
    check("t5_index",   16'(bus_s.index), 16'd7);
    check("t5_largest", bus_s.largest, 16'd9);
    check("t5_ovf",     16'(bus_s.ovf), 16'd1);
    beat_s(1'b1, 16'd4, 16'd1);
    idle_s();
    idle_s();
    check("t5_ovf_held", 16'(bus_s.ovf), 16'd1);
    idle_s();
    check("t5b_done",    16'(bus_s.done), 16'd1);
    check("t5b_index",   16'(bus_s.index), 16'd1);
    check("t5b_largest", bus_s.largest, 16'd4);
    check("t5b_ovf",     16'(bus_s.ovf), 16'd0);

    // Asynchronous reset between edges while a frame is in the pipeline.
    beat(1'b1, 1'b1, 1'b1, 1'b0, 16'd6, 16'd6);
    @(negedge CLKEXT);
    bus.trig = 1'b0;
    bus.last = 1'b0;
    #2 RST_COMP = 1'b1;
    #1;
    check("t6_rst_done",    16'(bus.done), 16'd0);
    check("t6_rst_busy",    16'(bus.busy), 16'd0);
    check("t6_rst_index",   16'(bus.index), 16'd0);
    check("t6_rst_largest", bus.largest, 16'h8000);
    check("t6_rst_ovf",     16'(bus.ovf), 16'd0);
    @(negedge CLKEXT);
    RST_COMP = 1'b0;
    idle();
    check("t6_no_done_a", 16'(bus.done), 16'd0);
    idle();
    check("t6_no_done_b", 16'(bus.done), 16'd0);
    check("t6_index_rst", 16'(bus.index), 16'd0);

    beat(1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
    idle();
    idle();
    idle();
    check_result("t6z", 16'd1, 16'd0);

    // trig with EN_COMP low is dropped, last flag included.
    beat(1'b0, 1'b1, 1'b1, 1'b0, 16'd7, 16'd7);
    idle();
    check("t6_en_done_a", 16'(bus.done), 16'd0);
    idle();
    check("t6_en_done_b", 16'(bus.done), 16'd0);
    idle();
    check("t6_en_done_c", 16'(bus.done), 16'd0);
    check("t6_en_index",  16'(bus.index), 16'd1);

    // Dropped beat mid-frame must not advance the position base.
    beat(1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1);
    beat(1'b0, 1'b1, 1'b1, 1'b0, 16'd8, 16'd0);
    beat(1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 16'd3);
    idle();
    idle();
    idle();
    check_result("t7", 16'd4, 16'd3);
    idle();
    check("t7_done_end", 16'(bus.done), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
